// File: rtl/util_sat_counter.sv
// rtl/util_sat_counter.sv - up/down-by-one counter saturating at both ends, with sticky overflow
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   inc_i       count up by one this cycle
//   dec_i       count down by one this cycle
//   ovf_clr_i   synchronous clear of overflow_o
//   count_o     current count (registered)
//   overflow_o  sticky flag, set when inc_i arrives with the count at its maximum
module util_sat_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             dec_i,
  input  logic             ovf_clr_i,
  output logic [WIDTH-1:0] count_o,
  output logic             overflow_o
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             ovf_set;

  always_comb begin
    count_d = count_q;
    ovf_set = 1'b0;
    // inc and dec together cancel, so only the lone-direction cases move the count.
    if (inc_i && !dec_i) begin
      if (count_q == CNT_MAX) begin
        ovf_set = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end else if (dec_i && !inc_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
    // A new overflow in the same cycle as a clear keeps the flag set.
    ovf_d = ovf_set | (ovf_q & ~ovf_clr_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_o    = count_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/util_pulse_stretch.sv
// rtl/util_pulse_stretch.sv - stretches single-cycle strobes into spaced level pulses, queueing overlaps
//
// Ports:
//   clk       rising-edge clock
//   res       asynchronous active-high reset
//   in        event strobe, one event per high cycle
//   ovf_clr   synchronous clear of overflow
//   out       stretched pulse, high exactly while in HIGH
//   busy      high while a pulse/gap is running or events are queued
//   pending   queued events not yet emitted
//   overflow  sticky, set when an event arrives with pending saturated
module util_pulse_stretch #(
  parameter int HIGH_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int CNT_BITS    = 4,
  parameter bit RETRIGGER   = 1'b0
) (
  input  logic                clk,
  input  logic                res,
  input  logic                in,
  input  logic                ovf_clr,
  output logic                out,
  output logic                busy,
  output logic [CNT_BITS-1:0] pending,
  output logic                overflow
);

  localparam int T_MAX = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
  localparam int TW    = $clog2(T_MAX + 1);

  localparam logic [TW-1:0] HIGH_LOAD = TW'(HIGH_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            cnt_inc;
  logic            cnt_dec;
  logic            pend_nz;

  assign pend_nz = (pending != '0);

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= S_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_inc = 1'b0;
    cnt_dec = 1'b0;
    case (state_q)
      S_IDLE: begin
        // The event is emitted straight away, so it never touches the queue.
        if (in) begin
          state_d = S_HIGH;
          timer_d = HIGH_LOAD;
        end
      end
      S_HIGH: begin
        if (RETRIGGER && in) begin
          timer_d = HIGH_LOAD;
        end else begin
          cnt_inc = in;
          if (timer_q == '0) begin
            state_d = S_GAP;
            timer_d = GAP_LOAD;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
      end
      S_GAP: begin
        if (timer_q == '0) begin
          if (pend_nz) begin
            // Replay the oldest queued event; a strobe this cycle joins the queue.
            state_d = S_HIGH;
            timer_d = HIGH_LOAD;
            cnt_dec = 1'b1;
            cnt_inc = in;
          end else if (in) begin
            state_d = S_HIGH;
            timer_d = HIGH_LOAD;
          end else begin
            state_d = S_IDLE;
            timer_d = '0;
          end
        end else begin
          timer_d = timer_q - 1'b1;
          cnt_inc = in;
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase
  end

  util_sat_counter #(
    .WIDTH(CNT_BITS)
  ) u_pend (
    .clk        (clk),
    .rst        (res),
    .inc_i      (cnt_inc),
    .dec_i      (cnt_dec),
    .ovf_clr_i  (ovf_clr),
    .count_o    (pending),
    .overflow_o (overflow)
  );

  // Outputs decode registered state only; nothing reaches them from the inputs combinationally.
  assign out  = (state_q == S_HIGH);
  assign busy = (state_q != S_IDLE) || pend_nz;

endmodule

// File: tb/tb_util_pulse_stretch.sv
// tb/tb_util_pulse_stretch.sv - directed vector bench for util_pulse_stretch
module tb_util_pulse_stretch;

  logic       clk;
  logic       res;
  logic       in0, clr0, in1, clr1;
  logic       out0, busy0, ovf0;
  logic       out1, busy1, ovf1;
  logic [1:0] pend0, pend1;

  int checks = 0;
  int errors = 0;

  util_pulse_stretch #(
    .HIGH_CYCLES(4), .GAP_CYCLES(2), .CNT_BITS(2), .RETRIGGER(1'b0)
  ) dut (
    .clk(clk), .res(res), .in(in0), .ovf_clr(clr0),
    .out(out0), .busy(busy0), .pending(pend0), .overflow(ovf0)
  );

  util_pulse_stretch #(
    .HIGH_CYCLES(4), .GAP_CYCLES(2), .CNT_BITS(2), .RETRIGGER(1'b1)
  ) dut_rt (
    .clk(clk), .res(res), .in(in1), .ovf_clr(clr1),
    .out(out1), .busy(busy1), .pending(pend1), .overflow(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       in_v;
    logic       clr;
    logic       out_e;
    logic       busy_e;
    logic [1:0] pend_e;
    logic       ovf_e;
  } vec_t;

  vec_t tbl[27];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    in0 = 0; clr0 = 0; in1 = 0; clr1 = 0;
    while ((busy0 || busy1) && n < 100) begin
      tick();
      n++;
    end
    chk(name, int'(busy0 | busy1), 0);
  endtask

  initial begin
    int hi_cnt;
    int pulses;
    logic prev;

    // saturation: strobes on 6 consecutive edges, drain, then clear overflow
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b1};
    tbl[18] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1};
    tbl[19] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1};
    tbl[20] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1};
    tbl[21] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1};
    tbl[22] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1};
    tbl[23] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1};
    tbl[24] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1};
    tbl[25] = '{1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
    tbl[26] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};

    res = 1'b1; in0 = 0; clr0 = 0; in1 = 0; clr1 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", int'(out0), 0);
    chk("reset_busy", int'(busy0), 0);
    chk("reset_pending", int'(pend0), 0);
    chk("reset_overflow", int'(ovf0), 0);
    chk("reset_rt_out", int'(out1), 0);
    res = 1'b0;
    tick();

    // single strobe: high 4 cycles, gap 2, then idle
    in0 = 1;
    for (int k = 0; k < 8; k++) begin
      tick();
      in0 = 0;
      chk($sformatf("single_out_%0d", k), int'(out0), (k < 4) ? 1 : 0);
      chk($sformatf("single_busy_%0d", k), int'(busy0), (k < 6) ? 1 : 0);
      chk($sformatf("single_pend_%0d", k), int'(pend0), 0);
    end

    // three strobes: pulses every 6 cycles, pending peaks at 2
    in0 = 1;
    tick(); tick();
    chk("three_pend_mid", int'(pend0), 1);
    tick();
    in0 = 0;
    chk("three_pend_peak", int'(pend0), 2);
    hi_cnt = 0;
    for (int k = 3; k < 20; k++) begin
      tick();
      chk($sformatf("three_out_%0d", k), int'(out0),
          ((k % 6) < 4 && k < 16) ? 1 : 0);
    end
    chk("three_overflow", int'(ovf0), 0);
    wait_idle("three_drain");

    // saturation table
    pulses = 0;
    prev = 1'b0;
    for (int i = 0; i < 27; i++) begin
      in0  = tbl[i].in_v;
      clr0 = tbl[i].clr;
      tick();
      chk($sformatf("tbl_out_%0d", i), int'(out0), int'(tbl[i].out_e));
      chk($sformatf("tbl_busy_%0d", i), int'(busy0), int'(tbl[i].busy_e));
      chk($sformatf("tbl_pend_%0d", i), int'(pend0), int'(tbl[i].pend_e));
      chk($sformatf("tbl_ovf_%0d", i), int'(ovf0), int'(tbl[i].ovf_e));
      if (out0 && !prev) pulses++;
      prev = out0;
    end
    chk("tbl_pulse_count", pulses, 4);
    in0 = 0; clr0 = 0;

    // strobe during the final gap cycle with pending=1 restarts HIGH at once
    in0 = 1;
    tick(); tick();
    in0 = 0;
    chk("lastgap_pend_before", int'(pend0), 1);
    repeat (4) tick();
    in0 = 1;
    tick();
    in0 = 0;
    chk("lastgap_out", int'(out0), 1);
    chk("lastgap_pend", int'(pend0), 1);
    wait_idle("lastgap_drain");

    // reset mid-pulse with pending=2
    in0 = 1;
    repeat (3) tick();
    in0 = 0;
    tick();
    chk("rst_pre_pend", int'(pend0), 2);
    #2 res = 1'b1;
    #1;
    chk("rst_out", int'(out0), 0);
    chk("rst_pend", int'(pend0), 0);
    chk("rst_busy", int'(busy0), 0);
    res = 1'b0;
    hi_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (out0) hi_cnt++;
    end
    chk("rst_no_more_pulses", hi_cnt, 0);

    // overflow set and clear in the same cycle: set wins
    in0 = 1;
    repeat (4) tick();
    chk("setclr_pre", int'(ovf0), 0);
    clr0 = 1;
    tick();
    chk("setclr_same_cycle", int'(ovf0), 1);
    in0 = 0;
    tick();
    clr0 = 0;
    chk("setclr_cleared", int'(ovf0), 0);
    wait_idle("setclr_drain");

    // retrigger: strobes 3 edges apart keep out high for 7 cycles
    in1 = 1;
    for (int k = 0; k < 10; k++) begin
      tick();
      in1 = (k == 2) ? 1'b1 : 1'b0;
      chk($sformatf("rt_out_%0d", k), int'(out1), (k <= 6) ? 1 : 0);
      chk($sformatf("rt_pend_%0d", k), int'(pend1), 0);
    end
    wait_idle("rt_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
